ps2_scancode_decoder: RTL and testbench
=======================================

// Module: ps2_scancode_decoder
// PURPOSE
//   Consumes raw set-2 bytes from the PS/2 keyboard receiver FIFO (data/ready/rdn handshake).
//   Strips E0/F0/E1 prefixes and tracks shift, ctrl and caps-lock.
//   Presents one key event at a time: code, ext, break and ASCII, held until the CPU acks it.
//   Sits between the keyboard receiver and the CPU I/O port.
// PARAMETERS
//   E1_SKIP   7   bytes discarded after an E1 prefix (Pause sequence tail)
// PORTS
//   clk           in   1  system clock (50 MHz)
//   rst           in   1  synchronous reset, active-high
//   ps2_data      in   8  receiver FIFO head byte
//   ps2_ready     in   1  receiver FIFO non-empty
//   ps2_overflow  in   1  receiver FIFO overflow flag
//   ps2_rdn       out  1  receiver pop strobe, active-low, registered
//   key_valid     out  1  event held on key_* outputs
//   key_ack       in   1  CPU consumed event; clears key_valid
//   key_code      out  8  scan code, prefixes stripped
//   key_ext       out  1  event was E0-prefixed
//   key_break     out  1  event is a release (F0-prefixed)
//   key_ascii     out  8  ASCII translation; 8'h00 if none
//   mod_shift     out  1  either shift held
//   mod_ctrl      out  1  either ctrl held
//   caps_lock     out  1  caps-lock toggle state
//   err           out  1  sticky error
//   err_clr       in   1  clears err
// BEHAVIOUR
//   Reset (sync, rst=1): FSM=IDLE; ps2_rdn=1; key_valid=0; key_code/key_ascii=0.
//     key_ext/key_break=0; modifiers, caps_lock, err=0; ext/brk prefix flags and skip counter=0.
//     Reset mid-fetch: the byte being popped is lost and no event is produced.
//   FSM: IDLE -> POP -> DECODE -> IDLE, so each byte takes 3 cycles.
//     IDLE: if ps2_ready && !key_valid, latch ps2_data, drive ps2_rdn<=0, go to POP.
//     POP: ps2_rdn<=1; go to DECODE. The receiver advances its read pointer at the end of the
//       cycle in which ps2_rdn is low.
//     DECODE: process the latched byte; go to IDLE. ps2_ready has settled before IDLE samples it.
//     ps2_rdn is low for exactly 1 cycle per byte and never low while ps2_ready=0.
//   Decode rules, in priority order:
//     skip counter != 0: decrement it; discard the byte.
//     E1: load E1_SKIP into skip counter; clear prefixes; no event.
//     E0: set ext flag.  F0: set brk flag.
//     00 or FF (keyboard overrun): set err; clear prefixes.
//     AA, FA, EE, FE (BAT, ack, echo, resend): discard; clear prefixes.
//     Any other byte: emit the event and clear both prefix flags.
//   Emit: key_code=byte, key_ext=ext, key_break=brk, key_ascii=lut, key_valid<=1.
//     All key_* outputs are stable until ack.
//   key_ack while key_valid=1: key_valid<=0 on the next edge.
//     key_ack while key_valid=0 is ignored.
//     A byte cannot be fetched while key_valid=1 (back-pressure); prefixes persist across the stall.
//   Modifiers are updated in DECODE before the ASCII lookup:
//     12/59 (ext=0): mod_shift = L|R held state.
//     14: mod_ctrl, tracked per ext value (left vs right ctrl).
//     58 make: caps_lock toggles; 58 break has no effect.
//   ASCII LUT (break events also carry ASCII):
//     letters 1C..: upper case if shift^caps_lock, else lower case.
//     digits 16,1E,26,25,2E,36,3D,3E,46,45 -> '1'..'9','0'; shift has no effect on digits.
//     29 -> 20 (space); 5A -> 0D (enter); 66 -> 08 (backspace); 0D -> 09 (tab).
//     Any byte with ext=1 -> 00.
//   err: set by ps2_overflow=1 on any cycle, or by code 00/FF. Cleared by err_clr.
//     Set wins if set and clear happen in the same cycle.
// CONFIGURATION
//   AUTOREPEAT_FILTER_EN defined:
//     A register holds {ext,code} of the last make; reset=9'h000.
//     A make equal to it is dropped (no event, no modifier change) until a matching break clears it.
//     A different make replaces it.
//   AUTOREPEAT_FILTER_EN undefined: every typematic make is emitted.
// TESTING
//   1C (make), then F0 1C (break), ack each -> event {1C,ext0,brk0,ascii 61}, then {1C,ext0,brk1,61}.
//     ps2_rdn low 1 cycle per byte.
//   12, then 1C -> second event ascii 41.
//     Then 58 (caps make), F0 58 (caps break), 1C -> ascii 61 (shift^caps=0).
//   E0 F0 75 -> single event {75,ext1,brk1,ascii 00}. No events for the prefix bytes.
//   E1 14 77 E1 F0 14 F0 77 then 29 -> only event is 29 (ascii 20).
//   Hold key_ack=0 with 3 bytes queued -> ps2_rdn stays high after the first event.
//     Ack -> remaining bytes fetched in order.
//   ps2_overflow pulse, then byte FF -> err=1 until err_clr; no key event.
//     rst asserted during POP -> all outputs at reset values next cycle.
//   AUTOREPEAT_FILTER_EN: 1C 1C 1C F0 1C -> exactly 2 events (make, break).
//     Without the macro -> 4 events.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Pulls raw set-2 bytes from the PS/2 receiver FIFO, strips E0/F0/E1 prefixes,
// tracks shift/ctrl/caps-lock and presents one key event at a time with ASCII,
// held until the CPU acknowledges it.
// Build option: define AUTOREPEAT_FILTER_EN to drop typematic repeats of a held key.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a byte while no unacknowledged event is pending
// S_POP    | byte latched, ps2_rdn low for this single cycle
// S_DECODE | act on the latched byte: skip, prefix, error, discard, event

module ps2_scancode_decoder #(
  parameter int E1_SKIP = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  input  logic       ps2_overflow,
  output logic       ps2_rdn,
  output logic       key_valid,
  input  logic       key_ack,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [7:0] key_ascii,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       caps_lock,
  output logic       err,
  input  logic       err_clr
);

  localparam int SKW = (E1_SKIP < 2) ? 1 : $clog2(E1_SKIP + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_DECODE
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     byte_q, byte_d;
  logic           rdn_q, rdn_d;
  logic           valid_q, valid_d;
  logic [7:0]     code_q, code_d;
  logic [7:0]     ascii_q, ascii_d;
  logic           kext_q, kext_d;
  logic           kbrk_q, kbrk_d;
  logic           ext_q, ext_d;
  logic           brk_q, brk_d;
  logic [SKW-1:0] skip_q, skip_d;
  logic           lshift_q, lshift_d;
  logic           rshift_q, rshift_d;
  logic           lctrl_q, lctrl_d;
  logic           rctrl_q, rctrl_d;
  logic           caps_q, caps_d;
  logic           err_q, err_d;
  logic           err_set;
  logic           drop;
`ifdef AUTOREPEAT_FILTER_EN
  logic [8:0]     last_q, last_d;
`endif

  // Set-2 scan code to ASCII; letters are case-folded by 'upper', extended codes map to 0.
  function automatic logic [7:0] ascii_lut(input logic [7:0] code, input logic ext,
                                           input logic upper);
    logic [7:0] letter;
    logic [7:0] res;
    letter = 8'h00;
    res    = 8'h00;
    case (code)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
      8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      default: letter = 8'h00;
    endcase
    case (code)
      8'h16: res = 8'h31; 8'h1E: res = 8'h32; 8'h26: res = 8'h33;
      8'h25: res = 8'h34; 8'h2E: res = 8'h35; 8'h36: res = 8'h36;
      8'h3D: res = 8'h37; 8'h3E: res = 8'h38; 8'h46: res = 8'h39;
      8'h45: res = 8'h30;
      8'h29: res = 8'h20;
      8'h5A: res = 8'h0D;
      8'h66: res = 8'h08;
      8'h0D: res = 8'h09;
      default: res = 8'h00;
    endcase
    if (letter != 8'h00) begin
      res = upper ? (letter - 8'h20) : letter;
    end
    if (ext) begin
      res = 8'h00;
    end
    return res;
  endfunction

  // Next-state, fetch handshake, prefix/modifier tracking and event capture.
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    rdn_d    = 1'b1;
    valid_d  = valid_q;
    code_d   = code_q;
    ascii_d  = ascii_q;
    kext_d   = kext_q;
    kbrk_d   = kbrk_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    skip_d   = skip_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    lctrl_d  = lctrl_q;
    rctrl_d  = rctrl_q;
    caps_d   = caps_q;
    err_set  = ps2_overflow;
    drop     = 1'b0;
`ifdef AUTOREPEAT_FILTER_EN
    last_d   = last_q;
`endif

    if (valid_q && key_ack) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (ps2_ready && !valid_q) begin
          byte_d  = ps2_data;
          rdn_d   = 1'b0;
          state_d = S_POP;
        end
      end
      S_POP: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_IDLE;
        if (skip_q != '0) begin
          skip_d = skip_q - SKW'(1);
        end else begin
          case (byte_q)
            8'hE1: begin
              skip_d = SKW'(E1_SKIP);
              ext_d  = 1'b0;
              brk_d  = 1'b0;
            end
            8'hE0: ext_d = 1'b1;
            8'hF0: brk_d = 1'b1;
            8'h00, 8'hFF: begin
              err_set = 1'b1;
              ext_d   = 1'b0;
              brk_d   = 1'b0;
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE: begin
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
            default: begin
              ext_d = 1'b0;
              brk_d = 1'b0;
`ifdef AUTOREPEAT_FILTER_EN
              // A repeated make of the key already down is typematic noise.
              if (!brk_q && (last_q == {ext_q, byte_q})) begin
                drop = 1'b1;
              end else if (!brk_q) begin
                last_d = {ext_q, byte_q};
              end else if (last_q == {ext_q, byte_q}) begin
                last_d = 9'h000;
              end
`endif
              if (!drop) begin
                if (!ext_q && (byte_q == 8'h12)) lshift_d = !brk_q;
                if (!ext_q && (byte_q == 8'h59)) rshift_d = !brk_q;
                if (byte_q == 8'h14) begin
                  if (ext_q) rctrl_d = !brk_q;
                  else       lctrl_d = !brk_q;
                end
                if ((byte_q == 8'h58) && !brk_q) caps_d = !caps_q;
                code_d  = byte_q;
                kext_d  = ext_q;
                kbrk_d  = brk_q;
                ascii_d = ascii_lut(byte_q, ext_q, (lshift_d | rshift_d) ^ caps_d);
                valid_d = 1'b1;
              end
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_d = err_set | (err_q & ~err_clr);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      byte_q   <= 8'h00;
      rdn_q    <= 1'b1;
      valid_q  <= 1'b0;
      code_q   <= 8'h00;
      ascii_q  <= 8'h00;
      kext_q   <= 1'b0;
      kbrk_q   <= 1'b0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      skip_q   <= '0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      lctrl_q  <= 1'b0;
      rctrl_q  <= 1'b0;
      caps_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef AUTOREPEAT_FILTER_EN
      last_q   <= 9'h000;
`endif
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      rdn_q    <= rdn_d;
      valid_q  <= valid_d;
      code_q   <= code_d;
      ascii_q  <= ascii_d;
      kext_q   <= kext_d;
      kbrk_q   <= kbrk_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      skip_q   <= skip_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      lctrl_q  <= lctrl_d;
      rctrl_q  <= rctrl_d;
      caps_q   <= caps_d;
      err_q    <= err_d;
`ifdef AUTOREPEAT_FILTER_EN
      last_q   <= last_d;
`endif
    end
  end

  assign ps2_rdn   = rdn_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_ext   = kext_q;
  assign key_break = kbrk_q;
  assign key_ascii = ascii_q;
  assign mod_shift = lshift_q | rshift_q;
  assign mod_ctrl  = lctrl_q | rctrl_q;
  assign caps_lock = caps_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: a behavioural receiver FIFO feeds bytes,
// a monitor records every key event, and each test task compares against hand-derived values.
module tb_ps2_scancode_decoder;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_ready = 1'b0;
  logic       ps2_overflow = 1'b0;
  logic       key_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic       ps2_rdn, key_valid, key_ext, key_break, mod_shift, mod_ctrl, caps_lock, err;
  logic [7:0] key_code, key_ascii;

  int tests = 0;
  int fails = 0;

  logic [7:0] fifo[$];
  ev_t        ev_q[$];
  ev_t        held;
  logic       kv_prev = 1'b0;
  logic       auto_ack = 1'b1;
  int         rdn_lows = 0;
  int         rdn_bad = 0;
  int         unstable = 0;

  ps2_scancode_decoder dut (
    .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_overflow(ps2_overflow), .ps2_rdn(ps2_rdn), .key_valid(key_valid),
    .key_ack(key_ack), .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
    .key_ascii(key_ascii), .mod_shift(mod_shift), .mod_ctrl(mod_ctrl),
    .caps_lock(caps_lock), .err(err), .err_clr(err_clr)
  );

  always #10 clk = ~clk;

  // Receiver FIFO model, event monitor and CPU ack, all away from the rising edge.
  always @(negedge clk) begin
    if (!ps2_rdn) begin
      rdn_lows++;
      if (!ps2_ready) rdn_bad++;
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    if (key_valid && !kv_prev) begin
      held = {key_code, key_ext, key_break, key_ascii};
      ev_q.push_back(held);
    end else if (key_valid && kv_prev && ({key_code, key_ext, key_break, key_ascii} !== held)) begin
      unstable++;
    end
    kv_prev   = key_valid;
    ps2_ready = (fifo.size() > 0);
    ps2_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    key_ack   = auto_ack && key_valid;
  end

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (fifo.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++;
    if ({ps2_rdn, key_valid, key_code, key_ascii} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
      fails++;
      $display("FAIL reset_out: got rdn=%b valid=%b code=%h ascii=%h required 1 0 00 00",
               ps2_rdn, key_valid, key_code, key_ascii);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({key_ext, key_break, mod_shift, mod_ctrl, caps_lock, err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b required 000000",
               {key_ext, key_break, mod_shift, mod_ctrl, caps_lock, err});
    end
  endtask

  task automatic test_make_break;
    ev_t exp [2] = '{{8'h1C, 1'b0, 1'b0, 8'h61}, {8'h1C, 1'b0, 1'b1, 8'h61}};
    int  base = ev_q.size();
    int  r0 = rdn_lows;
    bit  ok;
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL mb_drain: %0d bytes left required 0", fifo.size()); end
    tests++;
    if (ev_q.size() - base != 2) begin
      fails++; $display("FAIL mb_count: got %0d required 2", ev_q.size() - base);
    end
    foreach (exp[i]) if (base + i < ev_q.size()) begin
      tests++;
      if (ev_q[base + i] !== exp[i]) begin
        fails++; $display("FAIL mb_ev%0d: got %h required %h", i, ev_q[base + i], exp[i]);
      end
    end
    tests++;
    if (rdn_lows - r0 != 3) begin
      fails++; $display("FAIL mb_rdn_cycles: got %0d required 3", rdn_lows - r0);
    end
  endtask

  task automatic test_shift_caps;
    ev_t exp [12] = '{
      {8'h12, 1'b0, 1'b0, 8'h00}, {8'h1C, 1'b0, 1'b0, 8'h41}, {8'h1C, 1'b0, 1'b1, 8'h41},
      {8'h58, 1'b0, 1'b0, 8'h00}, {8'h58, 1'b0, 1'b1, 8'h00}, {8'h1C, 1'b0, 1'b0, 8'h61},
      {8'h1C, 1'b0, 1'b1, 8'h61}, {8'h12, 1'b0, 1'b1, 8'h00}, {8'h1C, 1'b0, 1'b0, 8'h41},
      {8'h1C, 1'b0, 1'b1, 8'h41}, {8'h58, 1'b0, 1'b0, 8'h00}, {8'h58, 1'b0, 1'b1, 8'h00}};
    int  base = ev_q.size();
    bit  ok;
    push(8'h12); push(8'h1C); push(8'hF0); push(8'h1C);
    push(8'h58); push(8'hF0); push(8'h58); push(8'h1C); push(8'hF0); push(8'h1C);
    drain(ok);
    tests++;
    if ({ok, mod_shift, caps_lock} !== 3'b111) begin
      fails++; $display("FAIL sc_mods_a: got ok/shift/caps=%b required 111", {ok, mod_shift, caps_lock});
    end
    push(8'hF0); push(8'h12); push(8'h1C); push(8'hF0); push(8'h1C);
    push(8'h58); push(8'hF0); push(8'h58);
    drain(ok);
    tests++;
    if ({ok, mod_shift, caps_lock} !== 3'b100) begin
      fails++; $display("FAIL sc_mods_b: got ok/shift/caps=%b required 100", {ok, mod_shift, caps_lock});
    end
    tests++;
    if (ev_q.size() - base != 12) begin
      fails++; $display("FAIL sc_count: got %0d required 12", ev_q.size() - base);
    end
    foreach (exp[i]) if (base + i < ev_q.size()) begin
      tests++;
      if (ev_q[base + i] !== exp[i]) begin
        fails++; $display("FAIL sc_ev%0d: got %h required %h", i, ev_q[base + i], exp[i]);
      end
    end
  endtask

  task automatic test_ctrl;
    logic [7:0] seq [4][3] = '{'{8'h14, 8'h00, 8'h00}, '{8'hE0, 8'h14, 8'h00},
                               '{8'hF0, 8'h14, 8'h00}, '{8'hE0, 8'hF0, 8'h14}};
    int   len [4] = '{1, 2, 2, 3};
    logic want [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    ev_t  exp [4] = '{{8'h14, 1'b0, 1'b0, 8'h00}, {8'h14, 1'b1, 1'b0, 8'h00},
                      {8'h14, 1'b0, 1'b1, 8'h00}, {8'h14, 1'b1, 1'b1, 8'h00}};
    int   base = ev_q.size();
    bit   ok;
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < len[s]; j++) push(seq[s][j]);
      drain(ok);
      tests++;
      if ({ok, mod_ctrl} !== {1'b1, want[s]}) begin
        fails++; $display("FAIL ctrl_stage%0d: got ok/ctrl=%b%b required 1%b", s, ok, mod_ctrl, want[s]);
      end
    end
    foreach (exp[i]) begin
      tests++;
      if (base + i >= ev_q.size()) begin
        fails++; $display("FAIL ctrl_ev%0d: got no event required %h", i, exp[i]);
      end else if (ev_q[base + i] !== exp[i]) begin
        fails++; $display("FAIL ctrl_ev%0d: got %h required %h", i, ev_q[base + i], exp[i]);
      end
    end
  endtask

  task automatic test_ext_break;
    ev_t exp [3] = '{{8'h75, 1'b1, 1'b1, 8'h00}, {8'h1C, 1'b1, 1'b0, 8'h00},
                     {8'h1C, 1'b1, 1'b1, 8'h00}};
    int  base = ev_q.size();
    bit  ok;
    push(8'hE0); push(8'hF0); push(8'h75);
    push(8'hE0); push(8'h1C); push(8'hE0); push(8'hF0); push(8'h1C);
    drain(ok);
    tests++;
    if (!ok || ev_q.size() - base != 3) begin
      fails++; $display("FAIL ext_count: got %0d events (drained=%b) required 3", ev_q.size() - base, ok);
    end
    foreach (exp[i]) if (base + i < ev_q.size()) begin
      tests++;
      if (ev_q[base + i] !== exp[i]) begin
        fails++; $display("FAIL ext_ev%0d: got %h required %h", i, ev_q[base + i], exp[i]);
      end
    end
  endtask

  task automatic test_e1_skip;
    logic [7:0] seq [10] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29, 8'hF0};
    ev_t exp [2] = '{{8'h29, 1'b0, 1'b0, 8'h20}, {8'h29, 1'b0, 1'b1, 8'h20}};
    int  base = ev_q.size();
    bit  ok;
    foreach (seq[i]) push(seq[i]);
    push(8'h29);
    drain(ok);
    tests++;
    if ({ok, mod_ctrl} !== 2'b10 || ev_q.size() - base != 2) begin
      fails++; $display("FAIL e1_count: got %0d events ctrl=%b drained=%b required 2 0 1",
                        ev_q.size() - base, mod_ctrl, ok);
    end
    foreach (exp[i]) if (base + i < ev_q.size()) begin
      tests++;
      if (ev_q[base + i] !== exp[i]) begin
        fails++; $display("FAIL e1_ev%0d: got %h required %h", i, ev_q[base + i], exp[i]);
      end
    end
  endtask

  task automatic test_lut;
    logic [7:0] seq [22] = '{8'h12, 8'h16, 8'hF0, 8'h16, 8'h45, 8'hF0, 8'h45, 8'hF0, 8'h12,
                             8'h5A, 8'h66, 8'h0D, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h1A, 8'hF0,
                             8'h1A, 8'h4D, 8'hF0, 8'hAA};
    ev_t exp [14] = '{
      {8'h12, 1'b0, 1'b0, 8'h00}, {8'h16, 1'b0, 1'b0, 8'h31}, {8'h16, 1'b0, 1'b1, 8'h31},
      {8'h45, 1'b0, 1'b0, 8'h30}, {8'h45, 1'b0, 1'b1, 8'h30}, {8'h12, 1'b0, 1'b1, 8'h00},
      {8'h5A, 1'b0, 1'b0, 8'h0D}, {8'h66, 1'b0, 1'b0, 8'h08}, {8'h0D, 1'b0, 1'b0, 8'h09},
      {8'h1A, 1'b0, 1'b0, 8'h7A}, {8'h1A, 1'b0, 1'b1, 8'h7A}, {8'h4D, 1'b0, 1'b0, 8'h70},
      {8'h29, 1'b0, 1'b0, 8'h20}, {8'h29, 1'b0, 1'b1, 8'h20}};
    int  base = ev_q.size();
    bit  ok;
    foreach (seq[i]) push(seq[i]);
    push(8'h29); push(8'hF0); push(8'h29);
    drain(ok);
    tests++;
    if (!ok || ev_q.size() - base != 14) begin
      fails++; $display("FAIL lut_count: got %0d events (drained=%b) required 14", ev_q.size() - base, ok);
    end
    foreach (exp[i]) if (base + i < ev_q.size()) begin
      tests++;
      if (ev_q[base + i] !== exp[i]) begin
        fails++; $display("FAIL lut_ev%0d: got %h required %h", i, ev_q[base + i], exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    ev_t exp [2] = '{{8'h2B, 1'b0, 1'b0, 8'h66}, {8'h2B, 1'b0, 1'b1, 8'h66}};
    int  base = ev_q.size();
    int  r0 = rdn_lows;
    int  r1;
    bit  seen = 1'b0;
    bit  ok;
    auto_ack = 1'b0;
    push(8'h2B); push(8'hF0); push(8'h2B);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (key_valid) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL b2b_first_event: got valid=0 required 1 within 50 cycles"); end
    r1 = rdn_lows;
    repeat (20) @(negedge clk);
    tests++;
    if (rdn_lows != r1 || fifo.size() != 2) begin
      fails++; $display("FAIL b2b_stall: got %0d pops, %0d queued required 0 pops, 2 queued",
                        rdn_lows - r1, fifo.size());
    end
    tests++;
    if ({key_valid, key_code, key_ascii} !== {1'b1, 8'h2B, 8'h66}) begin
      fails++; $display("FAIL b2b_hold: got valid=%b code=%h ascii=%h required 1 2b 66",
                        key_valid, key_code, key_ascii);
    end
    auto_ack = 1'b1;
    drain(ok);
    tests++;
    if (!ok || ev_q.size() - base != 2 || rdn_lows - r0 != 3) begin
      fails++; $display("FAIL b2b_count: got %0d events %0d pops required 2 events 3 pops",
                        ev_q.size() - base, rdn_lows - r0);
    end
    foreach (exp[i]) if (base + i < ev_q.size()) begin
      tests++;
      if (ev_q[base + i] !== exp[i]) begin
        fails++; $display("FAIL b2b_ev%0d: got %h required %h", i, ev_q[base + i], exp[i]);
      end
    end
    tests++;
    if (unstable != 0 || rdn_bad != 0) begin
      fails++; $display("FAIL b2b_protocol: got %0d unstable, %0d empty pops required 0 0", unstable, rdn_bad);
    end
  endtask

  task automatic test_error;
    ev_t exp [2] = '{{8'h1A, 1'b0, 1'b0, 8'h7A}, {8'h1A, 1'b0, 1'b1, 8'h7A}};
    int  base = ev_q.size();
    bit  ok;
    @(negedge clk) ps2_overflow = 1'b1;
    @(negedge clk) ps2_overflow = 1'b0;
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_ovf: got %b required 1", err); end
    push(8'hFF);
    drain(ok);
    tests++;
    if (err !== 1'b1 || ev_q.size() != base) begin
      fails++; $display("FAIL err_ff: got err=%b events=%0d required 1 0", err, ev_q.size() - base);
    end
    err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_clear: got %b required 0", err); end
    push(8'h00);
    drain(ok);
    tests++;
    if (err !== 1'b1 || ev_q.size() != base) begin
      fails++; $display("FAIL err_00: got err=%b events=%0d required 1 0", err, ev_q.size() - base);
    end
    err_clr = 1'b1;
    @(negedge clk) begin ps2_overflow = 1'b1; err_clr = 1'b1; end
    @(negedge clk) begin ps2_overflow = 1'b0; err_clr = 1'b0; end
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_set_wins: got %b required 1", err); end
    err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    push(8'hF0); push(8'hFF); push(8'h1A); push(8'hF0); push(8'h1A);
    drain(ok);
    tests++;
    if (err !== 1'b1 || ev_q.size() - base != 2) begin
      fails++; $display("FAIL err_prefix_clr: got err=%b events=%0d required 1 2", err, ev_q.size() - base);
    end
    foreach (exp[i]) if (base + i < ev_q.size()) begin
      tests++;
      if (ev_q[base + i] !== exp[i]) begin
        fails++; $display("FAIL err_ev%0d: got %h required %h", i, ev_q[base + i], exp[i]);
      end
    end
    err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
  endtask

  task automatic test_reset_midfetch;
    int base;
    bit ok;
    bit in_pop = 1'b0;
    push(8'h58); push(8'h12);
    drain(ok);
    @(negedge clk) ps2_overflow = 1'b1;
    @(negedge clk) ps2_overflow = 1'b0;
    tests++;
    if ({caps_lock, mod_shift, err, key_code} !== {3'b111, 8'h12}) begin
      fails++; $display("FAIL rst_pre: got caps/shift/err=%b code=%h required 111 12",
                        {caps_lock, mod_shift, err}, key_code);
    end
    base = ev_q.size();
    push(8'h1C);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ps2_rdn) begin in_pop = 1'b1; break; end
    end
    tests++;
    if (!in_pop) begin fails++; $display("FAIL rst_find_pop: got no rdn pulse required one within 20 cycles"); end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({ps2_rdn, key_valid, key_code, key_ascii, key_ext, key_break,
         mod_shift, mod_ctrl, caps_lock, err} !== {1'b1, 1'b0, 16'h0000, 6'b000000}) begin
      fails++; $display("FAIL rst_midfetch: got rdn=%b valid=%b code=%h ascii=%h flags=%b required 1 0 00 00 000000",
                        ps2_rdn, key_valid, key_code, key_ascii,
                        {key_ext, key_break, mod_shift, mod_ctrl, caps_lock, err});
    end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    tests++;
    if (ev_q.size() != base || fifo.size() != 0 || key_valid !== 1'b0) begin
      fails++; $display("FAIL rst_lost_byte: got %0d events valid=%b required 0 0", ev_q.size() - base, key_valid);
    end
  endtask

  task automatic test_autorepeat;
`ifdef AUTOREPEAT_FILTER_EN
    ev_t exp [2] = '{{8'h1C, 1'b0, 1'b0, 8'h61}, {8'h1C, 1'b0, 1'b1, 8'h61}};
`else
    ev_t exp [4] = '{{8'h1C, 1'b0, 1'b0, 8'h61}, {8'h1C, 1'b0, 1'b0, 8'h61},
                     {8'h1C, 1'b0, 1'b0, 8'h61}, {8'h1C, 1'b0, 1'b1, 8'h61}};
`endif
    int  base = ev_q.size();
    bit  ok;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain(ok);
    tests++;
    if (!ok || ev_q.size() - base != $size(exp)) begin
      fails++; $display("FAIL ar_count: got %0d events required %0d", ev_q.size() - base, $size(exp));
    end
    foreach (exp[i]) if (base + i < ev_q.size()) begin
      tests++;
      if (ev_q[base + i] !== exp[i]) begin
        fails++; $display("FAIL ar_ev%0d: got %h required %h", i, ev_q[base + i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_make_break;
    test_shift_caps;
    test_ctrl;
    test_ext_break;
    test_e1_skip;
    test_lut;
    test_back_to_back;
    test_error;
    test_reset_midfetch;
    test_autorepeat;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
